// File: rtl/pc_stack_unit.sv
// pc_stack_unit: picoMIPS program counter with absolute jump, call/return through a
// hardware return-address stack, stall and sticky stack error flag.
//
// Build option: define PC_STACK_EN to include the return stack. Without it PCcall acts
// as PCjump, PCret holds the PC (but still outranks lower-priority controls) and the
// flags are constant (stack_empty=1, stack_full=0, stack_err=0).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   stall        freeze PC, stack and error-set this cycle (err_clr still honoured)
//   PCincr       PC <= PC + 1
//   PCrelbranch  PC <= PC + signed Branchaddr
//   Branchaddr   two's-complement relative offset
//   PCjump       PC <= Jumpaddr
//   PCcall       push PC+1, PC <= Jumpaddr
//   PCret        PC <= popped return address
//   Jumpaddr     absolute target for PCjump/PCcall
//   err_clr      clears sticky stack_err
//   PCout        current program counter (registered)
//   stack_empty  no entries on the return stack (registered)
//   stack_full   StackDepth entries on the return stack (registered)
//   stack_err    sticky overflow/underflow flag
// Priority: stall > PCret > PCcall > PCjump > PCrelbranch > PCincr > hold.

module pc_stack_unit #(
  parameter int unsigned Psize      = 4,
  parameter int unsigned StackDepth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PCincr,
  input  logic             PCrelbranch,
  input  logic [Psize-1:0] Branchaddr,
  input  logic             PCjump,
  input  logic             PCcall,
  input  logic             PCret,
  input  logic [Psize-1:0] Jumpaddr,
  input  logic             err_clr,
  output logic [Psize-1:0] PCout,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  logic [Psize-1:0] pc_q, pc_d;
  logic [Psize-1:0] pc_inc;

  assign pc_inc = pc_q + Psize'(1);
  assign PCout  = pc_q;

`ifdef PC_STACK_EN
  // sp counts 0..StackDepth, so it needs one more code than the entry index.
  localparam int unsigned SpW  = $clog2(StackDepth + 1);
  localparam int unsigned IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [SpW-1:0] SpMax = SpW'(StackDepth);

  logic [Psize-1:0] stack_q [StackDepth];
  logic [SpW-1:0]   sp_q, sp_d, sp_m1;
  logic [IdxW-1:0]  push_idx, pop_idx;
  logic             push;
  logic             err_q, err_d;
  logic             empty_q, full_q;

  assign sp_m1    = sp_q - SpW'(1);
  assign push_idx = sp_q[IdxW-1:0];
  assign pop_idx  = sp_m1[IdxW-1:0];

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (err_clr) err_d = 1'b0;
    // A new error is applied after the clear so it wins in the same cycle.
    if (!stall) begin
      if (PCret) begin
        if (!empty_q) begin
          sp_d = sp_m1;
          pc_d = stack_q[pop_idx];
        end else begin
          err_d = 1'b1;
        end
      end else if (PCcall) begin
        if (!full_q) begin
          push = 1'b1;
          sp_d = sp_q + SpW'(1);
          pc_d = Jumpaddr;
        end else begin
          err_d = 1'b1;
        end
      end else if (PCjump) begin
        pc_d = Jumpaddr;
      end else if (PCrelbranch) begin
        pc_d = pc_q + Branchaddr;
      end else if (PCincr) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      empty_q <= (sp_d == '0);
      full_q  <= (sp_d == SpMax);
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign stack_err   = err_q;
`else
  logic unused_ok;
  assign unused_ok = err_clr ^ (StackDepth == 0);

  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (PCret) begin
        pc_d = pc_q;  // no stack: return is a no-op but still blocks lower controls
      end else if (PCcall || PCjump) begin
        pc_d = Jumpaddr;
      end else if (PCrelbranch) begin
        pc_d = pc_q + Branchaddr;
      end else if (PCincr) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (Psize=4, StackDepth=2). Each step drives controls
// on the falling edge, pushes the expected PC/flags to a scoreboard and pops/compares
// just after the next rising edge. Covers both builds of PC_STACK_EN.

module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall, PCincr, PCrelbranch, PCjump, PCcall, PCret, err_clr;
  logic [3:0] Branchaddr, Jumpaddr;
  logic [3:0] PCout;
  logic       stack_empty, stack_full, stack_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] pc;
    logic       e;
    logic       f;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];

  pc_stack_unit #(
    .Psize      (4),
    .StackDepth (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PCincr      (PCincr),
    .PCrelbranch (PCrelbranch),
    .Branchaddr  (Branchaddr),
    .PCjump      (PCjump),
    .PCcall      (PCcall),
    .PCret       (PCret),
    .Jumpaddr    (Jumpaddr),
    .err_clr     (err_clr),
    .PCout       (PCout),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    stall = 0; PCincr = 0; PCrelbranch = 0; PCjump = 0; PCcall = 0; PCret = 0;
    err_clr = 0; Branchaddr = 4'd0; Jumpaddr = 4'd0;
  endtask

  task automatic expect_now(input string tag, input logic [3:0] pc, input logic e,
                            input logic f, input logic err);
    exp_t x;
    x.pc = pc; x.e = e; x.f = f; x.err = err; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    logic [6:0] obs, want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed pc=%0d required an expected entry", PCout);
    end else begin
      x    = sb.pop_front();
      obs  = {PCout, stack_empty, stack_full, stack_err};
      want = {x.pc, x.e, x.f, x.err};
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s: observed pc=%0d empty/full/err=%b required pc=%0d empty/full/err=%b",
               x.tag, obs[6:3], obs[2:0], want[6:3], want[2:0]);
      end
    end
  endtask

  // Controls must already be set; expectation applies after the next rising edge.
  task automatic step(input string tag, input logic [3:0] pc, input logic e,
                      input logic f, input logic err);
    expect_now(tag, pc, e, f, err);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    idle();
    #1 reset = 1'b0;
    #2;
    expect_now("reset_state", 4'd0, 1'b1, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    reset = 1'b1;

    // Increment, relative branch, wrap
    @(negedge clk); idle(); PCincr = 1;                           step("incr1", 1, 1, 0, 0);
    @(negedge clk); idle(); PCincr = 1;                           step("incr2", 2, 1, 0, 0);
    @(negedge clk); idle(); PCincr = 1;                           step("incr3", 3, 1, 0, 0);
    @(negedge clk); idle(); PCrelbranch = 1; Branchaddr = 4'b1110; step("rel_m2", 1, 1, 0, 0);
    @(negedge clk); idle(); PCrelbranch = 1; Branchaddr = 4'b0000; step("rel_0", 1, 1, 0, 0);
    @(negedge clk); idle();                                       step("hold", 1, 1, 0, 0);
    @(negedge clk); idle(); PCjump = 1; Jumpaddr = 4'd15;         step("jump15", 15, 1, 0, 0);
    @(negedge clk); idle(); PCincr = 1;                           step("incr_wrap", 0, 1, 0, 0);
    @(negedge clk); idle(); PCjump = 1; Jumpaddr = 4'd1;          step("jump1", 1, 1, 0, 0);
    @(negedge clk); idle(); PCrelbranch = 1; Branchaddr = 4'b1101; step("rel_m3_wrap", 14, 1, 0, 0);
    @(negedge clk); idle(); PCrelbranch = 1; PCincr = 1; Branchaddr = 4'd1;
    step("rel_over_incr", 15, 1, 0, 0);

`ifdef PC_STACK_EN
    // Call/return nesting
    @(negedge clk); idle(); PCjump = 1; Jumpaddr = 4'd3;          step("jump3", 3, 1, 0, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd8;          step("call8", 8, 0, 0, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd12;         step("call12", 12, 0, 1, 0);
    @(negedge clk); idle(); PCret = 1;                            step("ret9", 9, 0, 0, 0);
    @(negedge clk); idle(); PCret = 1;                            step("ret4", 4, 1, 0, 0);
    // Overflow and underflow
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd8;          step("call8b", 8, 0, 0, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd12;         step("call12b", 12, 0, 1, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd5;          step("overflow", 12, 0, 1, 1);
    @(negedge clk); idle(); PCret = 1;                            step("ret_sticky", 9, 0, 0, 1);
    @(negedge clk); idle(); PCret = 1;                            step("ret5", 5, 1, 0, 1);
    @(negedge clk); idle(); PCret = 1;                            step("underflow", 5, 1, 0, 1);
    @(negedge clk); idle(); PCret = 1; err_clr = 1;               step("err_wins_clr", 5, 1, 0, 1);
    @(negedge clk); idle(); err_clr = 1;                          step("err_clr", 5, 1, 0, 0);
    // Stall and priority
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd2;          step("call2", 2, 0, 0, 0);
    @(negedge clk); idle(); stall = 1; PCincr = 1; PCcall = 1; Jumpaddr = 4'd9;
    step("stall_hold", 2, 0, 0, 0);
    @(negedge clk); idle(); PCret = 1; PCjump = 1; Jumpaddr = 4'd11; step("ret_over_jump", 6, 1, 0, 0);
    // Mid-clock asynchronous reset with PC=7, sp=1
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd10;         step("call10", 10, 0, 0, 0);
    @(negedge clk); idle(); PCjump = 1; Jumpaddr = 4'd7;          step("jump7", 7, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    expect_now("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    check_out();
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); idle(); PCret = 1;                            step("ret_after_reset", 0, 1, 0, 1);
    @(negedge clk); idle(); stall = 1; err_clr = 1; PCincr = 1;   step("stall_err_clr", 0, 1, 0, 0);
`else
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd6;          step("call_as_jump", 6, 1, 0, 0);
    @(negedge clk); idle(); PCret = 1;                            step("ret_noop", 6, 1, 0, 0);
    @(negedge clk); idle(); PCret = 1; PCjump = 1; Jumpaddr = 4'd3; step("ret_blocks_jump", 6, 1, 0, 0);
    @(negedge clk); idle(); stall = 1; PCincr = 1; PCcall = 1; Jumpaddr = 4'd9;
    step("stall_hold", 6, 1, 0, 0);
    @(negedge clk); idle(); err_clr = 1; PCcall = 1; Jumpaddr = 4'd9; step("call9", 9, 1, 0, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd13;         step("call13_no_ovf", 13, 1, 0, 0);
    @(negedge clk); idle(); PCcall = 1; Jumpaddr = 4'd7;          step("call7_no_ovf", 7, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    expect_now("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
    check_out();
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); idle(); PCincr = 1;                           step("incr_after_reset", 1, 1, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised picoMIPS program counter and successor to the basic pc block.
- Adds absolute jump, call/return via a hardware return-address stack, a stall input and error flags, on top of the existing increment and PC-relative branch.
- Drives the program-memory address. Sits between the decoder/control unit and program ROM.

Parameters:
Psize, 4, PC / address width in bits (legal 2..16)
StackDepth, 4, number of return-address stack entries (legal 1..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  1 = freeze PC and stack this cycle
PCincr  input  1  PC <= PC + 1
PCrelbranch  input  1  PC <= PC + signed Branchaddr
Branchaddr  input  Psize  two's-complement relative offset
PCjump  input  1  PC <= Jumpaddr
PCcall  input  1  push PC+1, PC <= Jumpaddr
PCret  input  1  PC <= popped return address
Jumpaddr  input  Psize  absolute target for PCjump/PCcall
err_clr  input  1  clears sticky stack_err
PCout  output  Psize  current program counter
stack_empty  output  1  no entries on return stack
stack_full  output  1  StackDepth entries on stack
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset=0, async): PCout=0, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care. Reset asserted mid-operation aborts everything immediately.
- PC register updates on the rising clk edge. New PCout is visible the cycle after the control input (1-cycle latency). No combinational path from inputs to PCout.
- Priority when several controls are high: stall > PCret > PCcall > PCjump > PCrelbranch > PCincr > hold.
- stall=1: PC, stack and flags hold. err_clr is still honoured.
- PCincr: PC+1 modulo 2^Psize. 2^Psize-1 wraps to 0.
- PCrelbranch: PC + Branchaddr, with Branchaddr treated as signed Psize bits, result modulo 2^Psize. An offset of 0 holds PC.
- PCjump: PC <= Jumpaddr.
- PCcall, stack not full: stack[sp] <= PC+1 (mod 2^Psize), sp <= sp+1, PC <= Jumpaddr.
- PCcall, stack full (overflow): no push, PC holds, stack_err <= 1.
- PCret, stack not empty: sp <= sp-1, PC <= stack[sp-1].
- PCret, stack empty (underflow): PC holds, sp stays 0, stack_err <= 1.
- Stack pointer range: 0..StackDepth. stack_empty = (sp==0), stack_full = (sp==StackDepth), both registered from sp.
- stack_err is sticky. err_clr=1 clears it next edge. If a new error and err_clr occur in the same cycle, the error wins (flag stays 1).
- No controls asserted: PC holds.

Optional Feature:
- Macro: PC_STACK_EN.
- Defined: return stack, PCcall/PCret semantics and all three flags as above.
- Undefined:
  - No stack storage.
  - PCcall behaves exactly as PCjump.
  - PCret is a no-op (PC holds).
  - stack_empty=1, stack_full=0, stack_err=0 constant.
  - err_clr ignored.
- Priority order otherwise unchanged.

Test Plan:
(Psize=4, StackDepth=2, PC_STACK_EN defined unless stated)
- Release reset, PCincr=1 for 3 cycles -> PCout 0,1,2,3; then PCrelbranch=1, Branchaddr=4'b1110 (-2) -> PCout=1; Branchaddr=0 -> PCout stays 1.
- PC=15, PCincr=1 -> PCout=0 (wrap). PC=1, PCrelbranch with Branchaddr=4'b1101 (-3) -> PCout=14.
- PC=3, PCcall with Jumpaddr=8 -> PCout=8, stack_empty=0; PCcall with Jumpaddr=12 -> PCout=12, stack_full=1; PCret -> PCout=9; PCret -> PCout=4, stack_empty=1.
- Stack full, PCcall with Jumpaddr=5 -> PCout unchanged, stack_err=1. Empty stack, PCret -> PCout unchanged, stack_err=1. err_clr=1 -> stack_err=0 next cycle.
- stall=1 with PCincr=1 and PCcall=1 -> PCout and sp unchanged. PCret and PCjump asserted together with non-empty stack -> the return wins.
- Assert reset low asynchronously mid-clock while PCout=7 and sp=1 -> PCout=0, stack_empty=1 immediately. Rebuild with PC_STACK_EN undefined: PCcall with Jumpaddr=6 -> PCout=6, PCret -> PCout stays 6, flags constant.
